// File: rtl/wb_port_arbiter.sv
// Merges even/odd write-back into two register-file ports. Registered, 1-cycle latency.
// Backpressure: even pipe never stalls; a same-address odd write waits one cycle in a hold buffer (op_ready low).
module wb_port_arbiter #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ep_valid,
   input  logic [ADDR_W-1:0] ep_addr,
   input  logic [DATA_W-1:0] ep_data,
   input  logic              op_valid,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_data,
   output logic              op_ready,
   output logic              rf_ep_wen,
   output logic [ADDR_W-1:0] rf_ep_addr,
   output logic [DATA_W-1:0] rf_ep_data,
   output logic              rf_op_wen,
   output logic [ADDR_W-1:0] rf_op_addr,
   output logic [DATA_W-1:0] rf_op_data,
   output logic [CNT_W-1:0]  conflict_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   typedef enum logic {EMPTY, HELD} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   logic              op_wen_nxt;
   logic [ADDR_W-1:0] op_addr_nxt;
   logic [DATA_W-1:0] op_data_nxt;
   logic              capture;
   logic              conflict;
   logic              drop;

   always_comb begin
      state_nxt   = state;
      op_wen_nxt  = 1'b0;
      op_addr_nxt = rf_op_addr;
      op_data_nxt = rf_op_data;
      capture     = 1'b0;
      conflict    = 1'b0;
      drop        = 1'b0;
      case (state)
         EMPTY: begin
            if (op_valid) begin
               // The odd result is younger, so on a collision it must land after the even one.
               if (ep_valid && (ep_addr == op_addr)) begin
                  capture   = 1'b1;
                  conflict  = 1'b1;
                  state_nxt = HELD;
               end else begin
                  op_wen_nxt  = 1'b1;
                  op_addr_nxt = op_addr;
                  op_data_nxt = op_data;
               end
            end
         end
         HELD: begin
            state_nxt = EMPTY;
            // A newer even write to the same register makes the held value dead.
            if (ep_valid && (ep_addr == hold_addr)) begin
               drop = 1'b1;
            end else begin
               op_wen_nxt  = 1'b1;
               op_addr_nxt = hold_addr;
               op_data_nxt = hold_data;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= EMPTY;
         op_ready     <= 1'b1;
         hold_addr    <= '0;
         hold_data    <= '0;
         rf_ep_wen    <= 1'b0;
         rf_ep_addr   <= '0;
         rf_ep_data   <= '0;
         rf_op_wen    <= 1'b0;
         rf_op_addr   <= '0;
         rf_op_data   <= '0;
         conflict_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         state      <= state_nxt;
         op_ready   <= (state_nxt == EMPTY);
         rf_ep_wen  <= ep_valid;
         if (ep_valid) begin
            rf_ep_addr <= ep_addr;
            rf_ep_data <= ep_data;
         end
         rf_op_wen  <= op_wen_nxt;
         rf_op_addr <= op_addr_nxt;
         rf_op_data <= op_data_nxt;
         if (capture) begin
            hold_addr <= op_addr;
            hold_data <= op_data;
         end
         if (conflict && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_ONE;
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios for wb_port_arbiter; expected writes are queued with their due cycle and
// checked by an independent monitor, register-level state is checked inline.
module tb_wb_port_arbiter;

   localparam int DW = 128;
   localparam int AW = 7;
   localparam int CW = 4;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          ep_valid = 1'b0;
   logic [AW-1:0] ep_addr = '0;
   logic [DW-1:0] ep_data = '0;
   logic          op_valid = 1'b0;
   logic [AW-1:0] op_addr = '0;
   logic [DW-1:0] op_data = '0;
   logic          op_ready;
   logic          rf_ep_wen, rf_op_wen;
   logic [AW-1:0] rf_ep_addr, rf_op_addr;
   logic [DW-1:0] rf_ep_data, rf_op_data;
   logic [CW-1:0] conflict_cnt, drop_cnt;

   int  n_vec = 0;
   int  n_bad = 0;
   int  cyc   = 0;
   wr_t ep_q[$];
   wr_t op_q[$];

   wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .ep_valid(ep_valid), .ep_addr(ep_addr), .ep_data(ep_data),
      .op_valid(op_valid), .op_addr(op_addr), .op_data(op_data),
      .op_ready(op_ready),
      .rf_ep_wen(rf_ep_wen), .rf_ep_addr(rf_ep_addr), .rf_ep_data(rf_ep_data),
      .rf_op_wen(rf_op_wen), .rf_op_addr(rf_op_addr), .rf_op_data(rf_op_data),
      .conflict_cnt(conflict_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_port(input string name, inout wr_t q[$], input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
      wr_t e;
      n_vec++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL %s unexpected write: got cyc=%0d addr=%0d data=%0h, want no write", name, cyc, a, d);
      end else begin
         e = q.pop_front();
         if (e.cyc != cyc || e.addr !== a || e.data !== d) begin
            n_bad++;
            $display("FAIL %s write: got cyc=%0d addr=%0d data=%0h, want cyc=%0d addr=%0d data=%0h",
                     name, cyc, a, d, e.cyc, e.addr, e.data);
         end
      end
   endtask

   // Monitor: every write presented on a port must be the oldest one expected, in its due cycle.
   always @(negedge clock) begin
      if (reset) begin
         if (rf_ep_wen) check_port("port0", ep_q, rf_ep_addr, rf_ep_data);
         if (rf_op_wen) check_port("port1", op_q, rf_op_addr, rf_op_data);
         if (rf_ep_wen && rf_op_wen) begin
            n_vec++;
            if (rf_ep_addr == rf_op_addr) begin
               n_bad++;
               $display("FAIL same_addr: got both ports on addr %0d, want distinct", rf_ep_addr);
            end
         end
      end
   end

   task automatic drive(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input logic ov, input logic [AW-1:0] oa, input logic [DW-1:0] od);
      @(negedge clock);
      ep_valid = ev; ep_addr = ea; ep_data = ed;
      op_valid = ov; op_addr = oa; op_data = od;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic exp_ep(input int off, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ep_q.push_back('{cyc + off, a, d});
   endtask

   task automatic exp_op(input int off, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_q.push_back('{cyc + off, a, d});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_op_ready"}, DW'(op_ready), DW'(1));
      check({tag, "_ep_wen"}, DW'(rf_ep_wen), '0);
      check({tag, "_op_wen"}, DW'(rf_op_wen), '0);
      check({tag, "_ep_addr"}, DW'(rf_ep_addr), '0);
      check({tag, "_op_addr"}, DW'(rf_op_addr), '0);
      check({tag, "_ep_data"}, rf_ep_data, '0);
      check({tag, "_op_data"}, rf_op_data, '0);
      check({tag, "_conflict"}, DW'(conflict_cnt), '0);
      check({tag, "_drop"}, DW'(drop_cnt), '0);
   endtask

   localparam logic [DW-1:0] DA = {4{32'hA0A0_0001}};
   localparam logic [DW-1:0] DB = {4{32'hB0B0_0002}};
   localparam logic [DW-1:0] DC = {4{32'hC0C0_0003}};
   localparam logic [DW-1:0] DD = {4{32'hD0D0_0004}};
   localparam logic [DW-1:0] DE = {4{32'hE0E0_0005}};
   localparam logic [DW-1:0] DF = {4{32'hF0F0_0006}};

   initial begin
      // Reset state
      @(negedge clock);
      @(negedge clock);
      check_zero("reset");
      reset = 1'b1;

      // Distinct addresses: both ports write next cycle
      drive(1'b1, 7'd5, DA, 1'b1, 7'd9, DB);
      exp_ep(1, 7'd5, DA);
      exp_op(1, 7'd9, DB);
      idle();
      check("s1_op_ready", DW'(op_ready), DW'(1));
      check("s1_conflict", DW'(conflict_cnt), '0);

      // Collision on 12, then idle: odd write lands one cycle after even write
      drive(1'b1, 7'd12, DA, 1'b1, 7'd12, DB);
      exp_ep(1, 7'd12, DA);
      exp_op(2, 7'd12, DB);
      idle();
      check("s2_op_ready_held", DW'(op_ready), DW'(0));
      check("s2_conflict", DW'(conflict_cnt), DW'(1));
      idle();
      check("s2_op_ready_free", DW'(op_ready), DW'(1));

      // Collision on 12, then a newer even write to 12 supersedes the held odd write
      drive(1'b1, 7'd12, DA, 1'b1, 7'd12, DB);
      exp_ep(1, 7'd12, DA);
      drive(1'b1, 7'd12, DC, 1'b1, 7'd12, DB);
      exp_ep(1, 7'd12, DC);
      idle();
      check("s3_drop", DW'(drop_cnt), DW'(1));
      check("s3_conflict", DW'(conflict_cnt), DW'(2));
      check("s3_op_ready", DW'(op_ready), DW'(1));

      // Collision on 3, then even write to 4: both ports fire in the same cycle
      drive(1'b1, 7'd3, DD, 1'b1, 7'd3, DE);
      exp_ep(1, 7'd3, DD);
      drive(1'b1, 7'd4, DF, 1'b1, 7'd3, DE);
      exp_ep(1, 7'd4, DF);
      exp_op(1, 7'd3, DE);
      idle();
      check("s4_op_ready", DW'(op_ready), DW'(1));
      check("s4_conflict", DW'(conflict_cnt), DW'(3));
      check("s4_drop", DW'(drop_cnt), DW'(1));

      // Collision on 0, then asynchronous reset while held: buffered write is lost
      drive(1'b1, 7'd0, DA, 1'b1, 7'd0, DB);
      exp_ep(1, 7'd0, DA);
      idle();
      check("s5_op_ready_held", DW'(op_ready), DW'(0));
      #2 reset = 1'b0;
      #1 check_zero("async_rst");
      #1 reset = 1'b1;
      idle();
      check("s5_op_ready_after", DW'(op_ready), DW'(1));
      idle();

      // 2^CW+3 back-to-back collisions, each resolved by a superseding even write
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         drive(1'b1, 7'd7, DW'(i), 1'b1, 7'd7, DW'(1000 + i));
         exp_ep(1, 7'd7, DW'(i));
         drive(1'b1, 7'd7, DW'(500 + i), 1'b1, 7'd7, DW'(1000 + i));
         exp_ep(1, 7'd7, DW'(500 + i));
      end
      idle();
      check("sat_conflict", DW'(conflict_cnt), {{(DW-CW){1'b0}}, {CW{1'b1}}});
      check("sat_drop", DW'(drop_cnt), {{(DW-CW){1'b0}}, {CW{1'b1}}});

      idle();
      idle();
      idle();
      check("ep_pending", DW'(ep_q.size()), '0);
      check("op_pending", DW'(op_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: DATA_W, default 128, register data width.
REQ-002 Parameter: ADDR_W, default 7, register address width (128 entries).
REQ-003 Parameter: CNT_W, default 16, conflict counter width.
REQ-004 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: ep_valid  input  1  even-pipe write-back request.
REQ-007 Port: ep_addr  input  ADDR_W  even-pipe RT address.
REQ-008 Port: ep_data  input  DATA_W  even-pipe result.
REQ-009 Port: op_valid  input  1  odd-pipe write-back request.
REQ-010 Port: op_addr  input  ADDR_W  odd-pipe RT address.
REQ-011 Port: op_data  input  DATA_W  odd-pipe result.
REQ-012 Port: op_ready  output  1  odd pipe may present a new request; low means the odd pipe is stalled.
REQ-013 Port: rf_ep_wen / rf_ep_addr / rf_ep_data  output  1 / ADDR_W / DATA_W  register-file write port 0.
REQ-014 Port: rf_op_wen / rf_op_addr / rf_op_data  output  1 / ADDR_W / DATA_W  register-file write port 1.
REQ-015 Port: conflict_cnt  output  CNT_W  number of same-address collisions detected.
REQ-016 Port: drop_cnt  output  CNT_W  number of held odd writes discarded as superseded.

Function
REQ-017 The even pipe is never stalled; an ep_valid request is always accepted.
REQ-018 An odd request is accepted only in a cycle where op_valid=1 and op_ready=1.
REQ-019 All rf_* outputs are registered; an accepted request appears on its rf port exactly 1 cycle after acceptance.
REQ-020 FSM states are EMPTY (hold buffer empty, op_ready=1) and HELD (one odd request buffered, op_ready=0); op_ready is a registered function of state.
REQ-021 EMPTY with both valid and ep_addr!=op_addr: both write next cycle on their own ports; state stays EMPTY.
REQ-022 EMPTY with both valid and ep_addr==op_addr: ep writes next cycle; op addr/data are captured into the hold buffer; rf_op_wen=0 next cycle; conflict_cnt increments; next state HELD.
REQ-023 The odd result is younger in program order; on a collision it SHALL land strictly after the even result.
REQ-024 HELD, ep_valid=0 or ep_addr!=buffered addr: the buffered request drives rf_op_* next cycle; ep writes normally when valid; next state EMPTY.
REQ-025 HELD, ep_valid=1 and ep_addr==buffered addr: the buffered request is discarded (superseded by the younger even write); rf_op_wen=0; drop_cnt increments; next state EMPTY.
REQ-026 In HELD, op_valid is ignored (op_ready=0); the odd pipe SHALL hold its request stable.
REQ-027 The two rf ports never carry the same address with both wen=1 in the same cycle.
REQ-028 conflict_cnt and drop_cnt saturate at all-ones; they never wrap.
REQ-029 Address comparison uses the full ADDR_W bits; register 0 receives no special treatment.

Reset
REQ-030 While reset=0: state=EMPTY, op_ready=1, rf_ep_wen=0, rf_op_wen=0, rf_*_addr=0, rf_*_data=0, both counters=0.
REQ-031 Reset asserted while in HELD discards the buffered request; it is never written.
REQ-032 The first acceptance occurs on the first rising edge with reset=1.

Verification
REQ-033 Scenario: ep(addr 5, data A) and op(addr 9, data B) in the same cycle -> next cycle rf_ep_wen=1 addr 5 data A, rf_op_wen=1 addr 9 data B; op_ready stays 1.
REQ-034 Scenario: ep(addr 12, data A) and op(addr 12, data B), then idle -> cycle+1: ep writes A to 12, rf_op_wen=0, op_ready=0, conflict_cnt=1; cycle+2: op writes B to 12, op_ready=1.
REQ-035 Scenario: collision on addr 12, then ep(addr 12, data C) in the HELD cycle -> C written via port 0, buffered B never written, drop_cnt=1, state EMPTY.
REQ-036 Scenario: collision on addr 3, then ep(addr 4) in the HELD cycle -> same cycle: port 0 writes addr 4, port 1 writes buffered addr 3.
REQ-037 Scenario: collision, then reset pulsed low mid-cycle while HELD -> all outputs zero immediately (asynchronous), op_ready=1, buffered write lost.
REQ-038 Scenario: 2^CNT_W+3 back-to-back collisions -> conflict_cnt holds all-ones and does not wrap.
